wb_page_interconnect: RTL and testbench

Parametrised single-master, NS-slave pipelined Wishbone interconnect that replaces the hand-written page decode, stall/ack/data muxing and bus-error logic at the top level. It sits between the host bus bridge (master) and the peripheral slaves (generator, LO/EFB bridge, info registers, …). Features:

- Table-driven page decode.
- Outstanding-transaction tracking.
- In-order enforcement across slave switches.
- A response timeout.
- Error capture with cause.

---
 rtl/wb_page_interconnect.sv | 171 +++++++++++++++++
 tb/tb_wb_page_interconnect.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_page_interconnect.sv
// Single-master, NS-slave pipelined Wishbone interconnect.
// Page-table decode, in-order response tracking across slave switches,
// response timeout and bus-error capture with cause and address.
module wb_page_interconnect #(
   parameter int NS = 4,
   parameter int AW = 30,
   parameter int DW = 32,
   parameter int PB = 8,
   parameter logic [NS*(AW-PB)-1:0] BASE_PAGES = {22'h84, 22'h83, 22'h82, 22'h81},
   parameter int OW = 3,
   parameter int TO_CYCLES = 1023
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_wb_cyc,
   input  logic               i_wb_stb,
   input  logic               i_wb_we,
   input  logic [AW-1:0]      i_wb_addr,
   input  logic [DW-1:0]      i_wb_data,
   input  logic [DW/8-1:0]    i_wb_sel,
   output logic               o_wb_stall,
   output logic               o_wb_ack,
   output logic               o_wb_err,
   output logic [DW-1:0]      o_wb_data,
   output logic               o_s_cyc,
   output logic [NS-1:0]      o_s_stb,
   output logic               o_s_we,
   output logic [PB-1:0]      o_s_addr,
   output logic [DW-1:0]      o_s_data,
   output logic [DW/8-1:0]    o_s_sel,
   input  logic [NS-1:0]      i_s_stall,
   input  logic [NS-1:0]      i_s_ack,
   input  logic [NS*DW-1:0]   i_s_data,
   output logic               o_err_stb,
   output logic [1:0]         o_err_cause,
   output logic [AW-1:0]      o_err_addr
);
   localparam int PW = AW - PB;
   localparam int SW = $clog2(NS + 1);
   localparam int TW = $clog2(TO_CYCLES + 1);
   // Index NS is the internal error target for unmapped pages.
   localparam logic [SW-1:0] SEL_E   = SW'(NS);
   localparam logic [OW-1:0] CNT_MAX = {OW{1'b1}};
   // Compare against the pre-increment value so the error lands exactly
   // TO_CYCLES clocks after the last accept or response.
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 2);

   logic [SW-1:0] cur_q, cur_d;
   logic [OW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [AW-1:0] last_addr_q, last_addr_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic          e_pend_q, e_pend_d;
   logic [DW-1:0] data_q, data_d;
   logic [1:0]    cause_q, cause_d;
   logic [AW-1:0] eaddr_q, eaddr_d;

   logic [PW-1:0] page;
   logic [SW-1:0] dsel;
   logic          sel_stall, cur_ack;
   logic [DW-1:0] cur_data;
   logic          req, accept, accept_e, resp_s, resp_e, resp, timeout;

   // Page decode: lowest matching slave index wins, no match selects E.
   always_comb begin
      page = i_wb_addr[AW-1:PB];
      dsel = SEL_E;
      for (int k = NS - 1; k >= 0; k--) begin
         if (page == BASE_PAGES[k*PW +: PW]) dsel = SW'(k);
      end
   end

   // Stall of the decoded slave, and ack/data of the slave holding the bus.
   always_comb begin
      sel_stall = 1'b0;
      cur_ack   = 1'b0;
      cur_data  = '0;
      for (int k = 0; k < NS; k++) begin
         if (dsel == SW'(k)) sel_stall = i_s_stall[k];
         if (cur_q == SW'(k)) begin
            cur_ack  = i_s_ack[k];
            cur_data = i_s_data[k*DW +: DW];
         end
      end
   end

   assign req        = i_wb_cyc & i_wb_stb;
   assign o_wb_stall = req & (((cnt_q != '0) & (dsel != cur_q)) |
                              (cnt_q == CNT_MAX) | sel_stall);
   assign accept     = req & ~o_wb_stall;
   assign accept_e   = accept & (dsel == SEL_E);
   // Acks from anything but the current target, or with nothing pending, drop.
   assign resp_s     = (cnt_q != '0) & cur_ack;
   assign resp_e     = (cnt_q != '0) & e_pend_q & (cur_q == SEL_E);
   assign resp       = resp_s | resp_e;
   assign timeout    = i_wb_cyc & (cnt_q != '0) & ~accept & ~resp &
                       (to_cnt_q == TO_LAST);

   // Strobe routing to the decoded slave only when the request is accepted.
   always_comb begin
      o_s_stb = '0;
      for (int k = 0; k < NS; k++) begin
         o_s_stb[k] = accept & (dsel == SW'(k));
      end
   end

   assign o_s_cyc  = i_wb_cyc;
   assign o_s_we   = i_wb_we;
   assign o_s_addr = i_wb_addr[PB-1:0];
   assign o_s_data = i_wb_data;
   assign o_s_sel  = i_wb_sel;

   // Next-state for tracking, response and error-capture registers.
   always_comb begin
      cur_d       = cur_q;
      last_addr_d = last_addr_q;
      cnt_d       = cnt_q;
      to_cnt_d    = to_cnt_q;
      if (accept) begin
         cur_d       = dsel;
         last_addr_d = i_wb_addr;
      end
      if (!i_wb_cyc || timeout)  cnt_d = '0;
      else if (accept && !resp)  cnt_d = cnt_q + 1'b1;
      else if (!accept && resp)  cnt_d = cnt_q - 1'b1;
      if (!i_wb_cyc || (cnt_q == '0) || accept || resp || timeout) to_cnt_d = '0;
      else                                                         to_cnt_d = to_cnt_q + 1'b1;
      ack_d    = i_wb_cyc & resp_s;
      data_d   = ack_d ? cur_data : '0;
      err_d    = i_wb_cyc & (accept_e | timeout);
      e_pend_d = accept_e;
      // Timeout takes priority over an unmapped access when both occur.
      cause_d  = timeout ? 2'b10 : (accept_e ? 2'b01 : cause_q);
      eaddr_d  = timeout ? last_addr_q : (accept_e ? i_wb_addr : eaddr_q);
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cur_q       <= '0;
         cnt_q       <= '0;
         to_cnt_q    <= '0;
         last_addr_q <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         e_pend_q    <= 1'b0;
         data_q      <= '0;
         cause_q     <= '0;
         eaddr_q     <= '0;
      end else begin
         cur_q       <= cur_d;
         cnt_q       <= cnt_d;
         to_cnt_q    <= to_cnt_d;
         last_addr_q <= last_addr_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         e_pend_q    <= e_pend_d;
         data_q      <= data_d;
         cause_q     <= cause_d;
         eaddr_q     <= eaddr_d;
      end
   end

   assign o_wb_ack    = ack_q;
   assign o_wb_err    = err_q;
   assign o_wb_data   = data_q;
   assign o_err_stb   = err_q;
   assign o_err_cause = cause_q;
   assign o_err_addr  = eaddr_q;
endmodule

// File: tb/tb_wb_page_interconnect.sv
// Bench for wb_page_interconnect: directed scenarios followed by a randomized
// run checked against a queue-based model of the outstanding requests.
module tb_wb_page_interconnect;
   localparam int NS = 4;
   localparam int AW = 30;
   localparam int DW = 32;
   localparam int PB = 8;
   localparam int OW = 3;
   localparam int TO = 16;

   logic              i_clk = 1'b0;
   logic              i_reset;
   logic              i_wb_cyc, i_wb_stb, i_wb_we;
   logic [AW-1:0]     i_wb_addr;
   logic [DW-1:0]     i_wb_data;
   logic [DW/8-1:0]   i_wb_sel;
   logic              o_wb_stall, o_wb_ack, o_wb_err;
   logic [DW-1:0]     o_wb_data;
   logic              o_s_cyc;
   logic [NS-1:0]     o_s_stb;
   logic              o_s_we;
   logic [PB-1:0]     o_s_addr;
   logic [DW-1:0]     o_s_data;
   logic [DW/8-1:0]   o_s_sel;
   logic [NS-1:0]     i_s_stall, i_s_ack;
   logic [NS*DW-1:0]  i_s_data;
   logic              o_err_stb;
   logic [1:0]        o_err_cause;
   logic [AW-1:0]     o_err_addr;

   wb_page_interconnect #(
      .NS(NS), .AW(AW), .DW(DW), .PB(PB), .OW(OW), .TO_CYCLES(TO)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
      .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
      .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
      .o_wb_data(o_wb_data),
      .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
      .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
      .i_s_stall(i_s_stall), .i_s_ack(i_s_ack), .i_s_data(i_s_data),
      .o_err_stb(o_err_stb), .o_err_cause(o_err_cause), .o_err_addr(o_err_addr)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int          tgt;
      int          ready;
      logic [31:0] data;
   } ent_t;

   int          checks = 0;
   int          errors = 0;
   int          pages [NS] = '{32'h81, 32'h82, 32'h83, 32'h84};
   ent_t        pend [$];
   ent_t        e;
   logic [31:0] got [$];
   logic [31:0] sw_exp [4] = '{32'h10000003, 32'h10000004, 32'h10000005, 32'h22222222};
   int          nack;
   int          d, r, k;
   logic        exp_ack, exp_err, exp_stall, acc;
   logic [31:0] exp_data;
   logic [AW-1:0] exp_eaddr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Page table lookup: first slave whose page matches, else the error target.
   function automatic int ref_decode(input logic [AW-1:0] a);
      for (int j = 0; j < NS; j++)
         if (int'(a[AW-1:PB]) == pages[j]) return j;
      return NS;
   endfunction

   initial begin
      i_reset = 1'b1; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
      i_wb_addr = '0; i_wb_data = '0; i_wb_sel = '0;
      i_s_stall = '0; i_s_ack = '0; i_s_data = '0;
      repeat (3) tick();
      i_reset = 1'b0;
      tick();
      chk("rst_ack", o_wb_ack, 0);
      chk("rst_err", o_wb_err, 0);
      chk("rst_data", o_wb_data, 0);
      chk("rst_estb", o_err_stb, 0);
      chk("rst_cause", o_err_cause, 0);
      chk("rst_eaddr", o_err_addr, 0);

      // Read from slave 0, ack two cycles after the strobe.
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_addr = 30'h8101; #1;
      chk("rd_stb", o_s_stb, 4'b0001);
      chk("rd_saddr", o_s_addr, 8'h01);
      chk("rd_stall", o_wb_stall, 0);
      tick(); i_wb_stb = 1'b0;
      chk("rd_ack_early", o_wb_ack, 0);
      tick(); i_s_ack = 4'b0001; i_s_data[31:0] = 32'h20170622;
      chk("rd_ack_wait", o_wb_ack, 0);
      tick(); i_s_ack = '0;
      chk("rd_ack", o_wb_ack, 1);
      chk("rd_data", o_wb_data, 32'h20170622);
      tick();
      chk("rd_ack_len", o_wb_ack, 0);
      chk("rd_idle_data", o_wb_data, 0);

      // Unmapped access.
      i_wb_stb = 1'b1; i_wb_addr = 30'h1234; #1;
      chk("um_stb", o_s_stb, 0);
      chk("um_stall", o_wb_stall, 0);
      tick(); i_wb_stb = 1'b0;
      chk("um_err", o_wb_err, 1);
      chk("um_estb", o_err_stb, 1);
      chk("um_cause", o_err_cause, 2'b01);
      chk("um_eaddr", o_err_addr, 30'h1234);
      chk("um_ack", o_wb_ack, 0);
      tick();
      chk("um_err_len", o_wb_err, 0);
      chk("um_estb_len", o_err_stb, 0);
      chk("um_cause_held", o_err_cause, 2'b01);

      // Three writes to slave 1 then a switch to slave 2.
      got.delete();
      for (int i = 0; i < 10; i++) begin
         tick();
         if (o_wb_ack) got.push_back(o_wb_data);
         i_wb_stb = (i <= 6); i_wb_we = 1'b1;
         i_wb_addr = (i < 3) ? 30'h8200 + 30'(i) : 30'h8300;
         i_s_ack = '0;
         i_s_ack[1] = (i >= 3 && i <= 5);
         i_s_data[63:32] = 32'h10000000 + 32'(i);
         i_s_ack[2] = (i == 7);
         i_s_data[95:64] = 32'h22222222;
         #1;
         chk("sw_stall", o_wb_stall, (i >= 3 && i <= 5));
         chk("sw_stb", o_s_stb, (i < 3) ? 4'b0010 : ((i == 6) ? 4'b0100 : 4'b0000));
      end
      chk("sw_nacks", got.size(), 4);
      for (int j = 0; j < got.size() && j < 4; j++) chk("sw_order", got[j], sw_exp[j]);

      // Outstanding limit on a non-acking slave 3.
      nack = 0; i_wb_we = 1'b0;
      for (int i = 0; i < 19; i++) begin
         tick();
         if (o_wb_ack) nack++;
         i_wb_stb = (i <= 9); i_wb_addr = 30'h8400 + 30'(i);
         i_s_ack = '0;
         i_s_ack[3] = (i == 8) || (i >= 10 && i <= 16);
         #1;
         if (i <= 9) begin
            chk("lim_stall", o_wb_stall, (i == 7 || i == 8));
            chk("lim_stb", o_s_stb, (i == 7 || i == 8) ? 4'b0000 : 4'b1000);
         end
      end
      chk("lim_nacks", nack, 8);

      // Timeout on slave 0, then an immediate access to slave 2.
      tick(); i_wb_stb = 1'b1; i_wb_addr = 30'h8155; #1;
      chk("to_stb", o_s_stb, 4'b0001);
      for (int i = 1; i <= TO; i++) begin
         tick(); i_wb_stb = 1'b0;
         if (i == TO) begin
            i_wb_stb = 1'b1; i_wb_addr = 30'h8300;
         end
         #1;
         chk("to_err", o_wb_err, (i == TO));
      end
      chk("to_estb", o_err_stb, 1);
      chk("to_cause", o_err_cause, 2'b10);
      chk("to_eaddr", o_err_addr, 30'h8155);
      chk("to_next_stall", o_wb_stall, 0);
      chk("to_next_stb", o_s_stb, 4'b0100);
      tick(); i_wb_stb = 1'b0; i_s_ack = 4'b0100; i_s_data[95:64] = 32'h5A5A0001;
      tick(); i_s_ack = '0;
      chk("to_next_ack", o_wb_ack, 1);
      chk("to_next_data", o_wb_data, 32'h5A5A0001);

      // Cycle abort with two outstanding, late acks discarded.
      tick(); i_wb_stb = 1'b1; i_wb_addr = 30'h8110;
      tick(); i_wb_addr = 30'h8111;
      tick(); i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_s_ack = 4'b0001;
      tick();
      chk("ab_ack0", o_wb_ack, 0);
      tick(); i_wb_cyc = 1'b1;
      chk("ab_ack1", o_wb_ack, 0);
      tick(); i_s_ack = '0; i_wb_stb = 1'b1; i_wb_addr = 30'h8300; #1;
      chk("ab_ack2", o_wb_ack, 0);
      chk("ab_stall", o_wb_stall, 0);
      chk("ab_stb", o_s_stb, 4'b0100);
      tick(); i_wb_addr = 30'h8301; i_s_ack = 4'b0100; i_s_data[95:64] = 32'hCAFE0001;
      chk("ab_ack3", o_wb_ack, 0);

      // Asynchronous reset in the middle of a burst.
      tick(); i_s_ack = '0; i_wb_addr = 30'h8100; #1;
      chk("pre_rst_ack", o_wb_ack, 1);
      chk("pre_rst_stall", o_wb_stall, 1);
      i_reset = 1'b1; #1;
      chk("mid_rst_ack", o_wb_ack, 0);
      chk("mid_rst_data", o_wb_data, 0);
      chk("mid_rst_err", o_wb_err, 0);
      chk("mid_rst_estb", o_err_stb, 0);
      chk("mid_rst_cause", o_err_cause, 0);
      chk("mid_rst_eaddr", o_err_addr, 0);
      chk("mid_rst_stall", o_wb_stall, 0);
      i_wb_stb = 1'b0;
      tick(); i_reset = 1'b0;

      // Randomized traffic against the outstanding-queue model.
      pend.delete(); exp_ack = 1'b0; exp_err = 1'b0; exp_data = '0; exp_eaddr = '0;
      for (int t = 0; t < 3000; t++) begin
         tick();
         chk("r_ack", o_wb_ack, exp_ack);
         chk("r_data", o_wb_data, exp_ack ? exp_data : 32'h0);
         chk("r_err", o_wb_err, exp_err);
         chk("r_estb", o_err_stb, exp_err);
         if (exp_err) begin
            chk("r_cause", o_err_cause, 2'b01);
            chk("r_eaddr", o_err_addr, exp_eaddr);
         end
         exp_ack = 1'b0; exp_err = 1'b0;

         i_wb_stb  = ($urandom_range(0, 3) != 0);
         i_wb_we   = 1'($urandom);
         i_wb_data = $urandom;
         i_wb_sel  = 4'($urandom);
         r = $urandom_range(0, NS);
         if (r < NS) i_wb_addr = 30'(pages[r] * 256 + $urandom_range(0, 255));
         else        i_wb_addr = 30'($urandom_range(0, 32'h80) * 256 + $urandom_range(0, 255));
         i_s_stall = 4'($urandom) & 4'($urandom);
         i_s_ack = '0;
         if (pend.size() > 0 && pend[0].tgt < NS && pend[0].ready <= t) begin
            i_s_ack[pend[0].tgt] = 1'b1;
            i_s_data[pend[0].tgt*DW +: DW] = pend[0].data;
         end
         if ($urandom_range(0, 7) == 0) begin
            k = $urandom_range(0, NS - 1);
            if (pend.size() == 0 || pend[0].tgt != k) i_s_ack[k] = 1'b1;
         end
         #1;

         d = ref_decode(i_wb_addr);
         exp_stall = i_wb_stb && ((pend.size() != 0 && pend[0].tgt != d) ||
                                  pend.size() == 7 || (d < NS && i_s_stall[d]));
         acc = i_wb_stb && !exp_stall;
         chk("r_stall", o_wb_stall, exp_stall);
         chk("r_stb", o_s_stb, (acc && d < NS) ? (4'b0001 << d) : 4'b0000);
         chk("r_saddr", o_s_addr, i_wb_addr[7:0]);

         if (pend.size() > 0 && pend[0].tgt < NS && pend[0].ready <= t) begin
            exp_ack  = 1'b1;
            exp_data = pend[0].data;
            void'(pend.pop_front());
         end else if (pend.size() > 0 && pend[0].tgt == NS) begin
            void'(pend.pop_front());
         end
         if (acc) begin
            if (d == NS) begin
               exp_err   = 1'b1;
               exp_eaddr = i_wb_addr;
            end
            e.tgt   = d;
            e.ready = t + $urandom_range(1, 4);
            e.data  = $urandom;
            pend.push_back(e);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
